// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register plus a four-state memory-request FSM.
// Define FETCH_TIMEOUT_EN to add a REQ-cycle timeout that parks the FSM in ERR.
module fetch_unit #(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              incr_pc,
  input  logic              load_pc,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err,
  output logic [3:0]        dbg_state
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t state_q, state_d;
  logic   req_start;
  logic   req_ack;
  logic   to_hit;

  assign req_start = (state_q == IDLE) && fetch_en;
  assign req_ack   = (state_q == REQ) && mem_ack;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt;

  // Counts consecutive ack-less REQ cycles; the cycle that would make it reach
  // TIMEOUT is the last REQ cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             to_cnt <= '0;
    else if (req_start)                  to_cnt <= '0;
    else if (state_q == REQ && !mem_ack) to_cnt <= to_cnt + 8'd1;
    else if (req_ack)                    to_cnt <= '0;
  end

  assign to_hit = (state_q == REQ) && !mem_ack && (to_cnt == TO_LIM);
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fetch_en) state_d = REQ;
      REQ: begin
        if (mem_ack)     state_d = DONE;
        else if (to_hit) state_d = ERR;
      end
      DONE: if (!fetch_en) state_d = IDLE;
`ifdef FETCH_TIMEOUT_EN
      ERR: if (load_pc) state_d = IDLE;
`else
      ERR: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // load_pc wins over incr_pc; both act in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pc <= RESET_PC;
    else if (load_pc) pc <= load_addr;
    else if (incr_pc) pc <= pc + 1'b1;
  end

  // mem_addr is captured only on REQ entry, so PC updates never disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            mem_addr <= RESET_PC;
    else if (req_start) mem_addr <= pc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          instr <= '0;
    else if (req_ack) instr <= mem_rdata;
  end

  assign mem_req     = (state_q == REQ);
  assign fetch_ready = (state_q == DONE);

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = (state_q == ERR);
`else
  assign fetch_err = 1'b0;
`endif

  assign dbg_state = {fetch_err, fetch_ready, mem_req, state_q == IDLE};

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit; timeout checks follow FETCH_TIMEOUT_EN.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en, incr_pc, load_pc, mem_ack;
  logic [15:0] load_addr, mem_rdata;
  logic        mem_req, fetch_ready, fetch_err;
  logic [15:0] mem_addr, instr, pc;
  logic [3:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .incr_pc(incr_pc),
    .load_pc(load_pc), .load_addr(load_addr), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .fetch_ready(fetch_ready), .instr(instr), .pc(pc),
    .fetch_err(fetch_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 0; incr_pc = 0; load_pc = 0; mem_ack = 0;
    load_addr = '0; mem_rdata = '0;
    #2;
    chk("rst_dbg",   dbg_state, 4'b0001);
    chk("rst_pc",    pc, 16'h0000);
    chk("rst_addr",  mem_addr, 16'h0000);
    chk("rst_instr", instr, 16'h0000);
    chk("rst_req",   mem_req, 0);
    chk("rst_rdy",   fetch_ready, 0);
    chk("rst_err",   fetch_err, 0);
    step();
    rst = 1'b0;

    // Single-cycle fetch; ack already high while IDLE must be ignored
    fetch_en = 1; mem_ack = 1; mem_rdata = 16'hA5C3;
    step();
    chk("t1_req",   mem_req, 1);
    chk("t1_dbg",   dbg_state, 4'b0010);
    chk("t1_addr",  mem_addr, 16'h0000);
    chk("t1_rdy0",  fetch_ready, 0);
    chk("t1_instr0", instr, 16'h0000);
    step();
    chk("t1_req_off", mem_req, 0);
    chk("t1_rdy",   fetch_ready, 1);
    chk("t1_instr", instr, 16'hA5C3);
    step();
    chk("t1_hold_done", dbg_state, 4'b0100);
    fetch_en = 0; mem_ack = 0;
    step();
    chk("t1_idle",  dbg_state, 4'b0001);
    chk("t1_keep",  instr, 16'hA5C3);

    // Delayed ack with incr_pc pulsed mid-REQ
    fetch_en = 1; mem_rdata = 16'h1234;
    step();
    for (int i = 0; i < 6; i++) begin
      chk("t2_req",  mem_req, 1);
      chk("t2_addr", mem_addr, 16'h0000);
      incr_pc = (i == 1);
      mem_ack = (i == 5);
      step();
    end
    incr_pc = 0; mem_ack = 0;
    chk("t2_rdy",   fetch_ready, 1);
    chk("t2_req_off", mem_req, 0);
    chk("t2_instr", instr, 16'h1234);
    chk("t2_pc",    pc, 16'h0001);
    fetch_en = 0;
    step();
    chk("t2_idle",  dbg_state, 4'b0001);

    // PC wrap and load priority
    load_pc = 1; load_addr = 16'hFFFF;
    step();
    chk("t3_load",  pc, 16'hFFFF);
    load_pc = 0; incr_pc = 1;
    step();
    chk("t3_wrap",  pc, 16'h0000);
    load_pc = 1; load_addr = 16'h0100;
    step();
    chk("t3_prio",  pc, 16'h0100);
    load_pc = 0; incr_pc = 0;

    // fetch_en dropped in REQ does not abort
    fetch_en = 1;
    step();
    chk("t4_addr",  mem_addr, 16'h0100);
    step();
    fetch_en = 0;
    step();
    chk("t4_noabort", dbg_state, 4'b0010);
    mem_ack = 1; mem_rdata = 16'hBEEF;
    step();
    chk("t4_rdy",   fetch_ready, 1);
    chk("t4_instr", instr, 16'hBEEF);
    mem_rdata = 16'h0000;
    step();
    chk("t4_idle",  dbg_state, 4'b0001);
    chk("t4_rdy0",  fetch_ready, 0);
    step();
    chk("t4_ignore", instr, 16'hBEEF);
    mem_ack = 0;

    // Timeout behaviour
    fetch_en = 1;
    step();
`ifdef FETCH_TIMEOUT_EN
    for (int i = 1; i < 15; i++) step();
    chk("t5_req15", dbg_state, 4'b0010);
    step();
    chk("t5_err_dbg", dbg_state, 4'b1000);
    chk("t5_err",   fetch_err, 1);
    chk("t5_req",   mem_req, 0);
    chk("t5_rdy",   fetch_ready, 0);
    chk("t5_instr", instr, 16'hBEEF);
    fetch_en = 0;
    step();
    chk("t5_stay",  dbg_state, 4'b1000);
    load_pc = 1; load_addr = 16'h0042;
    step();
    load_pc = 0;
    chk("t5_exit",  dbg_state, 4'b0001);
    chk("t5_err0",  fetch_err, 0);
    chk("t5_pc",    pc, 16'h0042);
`else
    for (int i = 0; i < 40; i++) step();
    chk("t5_wait",  dbg_state, 4'b0010);
    chk("t5_err0",  fetch_err, 0);
    mem_ack = 1;
    step();
    mem_ack = 0; fetch_en = 0;
    step();
    chk("t5_idle",  dbg_state, 4'b0001);
`endif

    // Reset mid-REQ drops mem_req immediately; later ack ignored
    fetch_en = 1;
    step();
    chk("t6_req",   mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_req_off", mem_req, 0);
    chk("t6_dbg",   dbg_state, 4'b0001);
    chk("t6_pc",    pc, 16'h0000);
    step();
    rst = 1'b0; fetch_en = 0; mem_ack = 1; mem_rdata = 16'hDEAD;
    step();
    chk("t6_instr", instr, 16'h0000);
    chk("t6_idle",  dbg_state, 4'b0001);
    mem_ack = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
